// File: rtl/rv32_pkg.sv
// Shared RV32 writeback types and constants for the register-file write path.
package rv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // Arbitration state: which requester won the most recent accepted transfer.
  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } last_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant register doubles as the FSM state.
module rr_arbiter2
  import rv32_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       last_grant
);

  last_e state_q, state_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= LAST1;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through this block leaves an output unassigned (no latch).
    gnt     = 2'b00;
    state_d = state_q;
    // No grants during stall or while reset is asserted.
    if (!hold && rst) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (state_q == LAST1) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    if (gnt[0]) begin
      state_d = LAST0;
    end else if (gnt[1]) begin
      state_d = LAST1;
    end
  end

  assign last_grant = (state_q == LAST1);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between ALU (req0) and load unit (req1) with one output register stage.
module regfile_wb_arbiter
  import rv32_pkg::*;
#(
  parameter int DATA_WIDTH       = XLEN,
  parameter int ADDR_WIDTH       = REG_ADDR_W,
  parameter bit ZERO_REG_DISCARD = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  last_grant
);

  logic [1:0]            gnt;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  discard;

  logic                  wr_en_q,   wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .req        ({req1_valid, req0_valid}),
    .gnt        (gnt),
    .last_grant (last_grant)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_comb begin
    sel_addr  = gnt[1] ? req1_addr : req0_addr;
    sel_data  = gnt[1] ? req1_data : req0_data;
    // x0 writes are accepted upstream but must never reach the regfile.
    discard   = ZERO_REG_DISCARD && (sel_addr == ADDR_WIDTH'(REG_ZERO));
    wr_en_d   = (|gnt) && !discard;
    wr_addr_d = wr_en_d ? sel_addr : wr_addr_q;
    wr_data_d = wr_en_d ? sel_data : wr_data_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the payload register is reset too, so forwarding logic never sees X after reset.
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scoreboard bench: stimulus queues expected writes, a negedge monitor retires them.
module tb_regfile_wb_arbiter;
  import rv32_pkg::*;

  logic        clk;
  logic        rst;
  logic        hold;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        last_grant;

  int total = 0;
  int bad   = 0;
  wb_req_t exp_q[$];

  localparam logic [31:0] DATA_A = 32'hAAAA_5555;
  localparam logic [31:0] DATA_B = 32'hBBBB_CCCC;

  regfile_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .last_grant (last_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", nm, got, want, $time);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wb_req_t e;
    e.valid = 1'b1;
    e.addr  = a;
    e.data  = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic h);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    hold       = h;
  endtask

  // Check handshake and arbitration state mid-cycle, then advance to just after the next edge.
  task automatic cyc(input string nm, input logic r0, input logic r1, input logic lg);
    @(negedge clk);
    check({nm, "_ready0"}, 32'(req0_ready), 32'(r0));
    check({nm, "_ready1"}, 32'(req1_ready), 32'(r1));
    check({nm, "_lastg"},  32'(last_grant), 32'(lg));
    @(posedge clk);
    #1;
  endtask

  // Monitor: every registered write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst && wr_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got write %0d/%h want none at %0t", wr_addr, wr_data, $time);
      end else begin
        wb_req_t e;
        e = exp_q.pop_front();
        check("sb_addr", 32'(wr_addr), 32'(e.addr));
        check("sb_data", wr_data, e.data);
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 1'b0);
    #1 rst = 1'b0;
    #2;
    check("rst_wr_en",   32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_lastg",   32'(last_grant), 32'd1);
    check("rst_ready0",  32'(req0_ready), 32'd0);
    check("rst_ready1",  32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_hold_lastg", 32'(last_grant), 32'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Single request from req0.
    drive(1'b1, 5'd5, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 1'b0);
    push(5'd5, 32'hFFFF_FFFF);
    cyc("single", 1'b1, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    cyc("single_idle", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("idle_wr_en",   32'(wr_en), 32'd0);
    check("idle_wr_addr", 32'(wr_addr), 32'd5);
    check("idle_wr_data", wr_data, 32'hFFFF_FFFF);
    @(posedge clk); #1;

    // Write to x0 from req1: accepted, flips last_grant, never reaches the port.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFFFF_0000, 1'b0);
    cyc("x0", 1'b0, 1'b1, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    @(negedge clk);
    check("x0_lastg",   32'(last_grant), 32'd1);
    check("x0_wr_en",   32'(wr_en), 32'd0);
    check("x0_wr_addr", 32'(wr_addr), 32'd5);
    check("x0_wr_data", wr_data, 32'hFFFF_FFFF);
    @(posedge clk); #1;

    // Contest: both held valid, grants alternate starting with req0.
    drive(1'b1, 5'd1, DATA_A, 1'b1, 5'd2, DATA_B, 1'b0);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push(5'd1, DATA_A);
      else            push(5'd2, DATA_B);
      cyc("contest", (k % 2 == 0), (k % 2 == 1), (k % 2 == 0));
    end

    // Stall with both valid: nothing granted, state frozen.
    hold = 1'b1;
    for (int k = 0; k < 3; k++) cyc("hold", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("hold_wr_en",   32'(wr_en), 32'd0);
    check("hold_wr_addr", 32'(wr_addr), 32'd2);
    check("hold_wr_data", wr_data, DATA_B);
    @(posedge clk); #1;
    hold = 1'b0;
    push(5'd1, DATA_A);
    cyc("release0", 1'b1, 1'b0, 1'b1);
    push(5'd2, DATA_B);
    cyc("release1", 1'b0, 1'b1, 1'b0);

    // Async reset landing while a write is on the port.
    drive(1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 32'h0, 1'b0);
    cyc("pre_rst", 1'b1, 1'b0, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    check("inflight_wr_en",   32'(wr_en), 32'd1);
    check("inflight_wr_addr", 32'(wr_addr), 32'd7);
    #1 rst = 1'b0;
    #1;
    check("async_wr_en",   32'(wr_en), 32'd0);
    check("async_wr_addr", 32'(wr_addr), 32'd0);
    check("async_wr_data", wr_data, 32'd0);
    check("async_lastg",   32'(last_grant), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
